// File: rtl/matmul_pkg.sv
// matmul_pkg: shared run-controller state encodings and DMEM map defaults
package matmul_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;
  localparam logic [15:0] RES_BASE_DEF = 16'h0040;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PULSE    = 3'd1;
  localparam logic [2:0] S_WAIT_END = 3'd2;
  localparam logic [2:0] S_RD_REQ   = 3'd3;
  localparam logic [2:0] S_RD_WAIT  = 3'd4;
  localparam logic [2:0] S_SEND     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_TOUT     = 3'd7;
  function automatic logic is_idle_like(logic [2:0] s);
    return s == S_IDLE || s == S_DONE || s == S_TOUT;
  endfunction
endpackage

// File: rtl/matmul_run_ctrl_if.sv
// matmul_run_ctrl_if: DMEM read port plus result stream between run controller and system
interface matmul_run_ctrl_if import matmul_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_last;
  modport master (output rd_en, rd_addr, res_valid, res_data, res_last, input rd_data, res_ready);
  modport slave  (input rd_en, rd_addr, res_valid, res_data, res_last, output rd_data, res_ready);
endinterface

// File: rtl/matmul_res_reader.sv
// matmul_res_reader: reads RES_WORDS words from DMEM one at a time and streams them out
module matmul_res_reader import matmul_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter logic [AW-1:0] RES_BASE = AW'(RES_BASE_DEF),
  parameter int RES_WORDS = 16
)(
  input  logic clk,
  input  logic RESET_N,
  input  logic go,
  output logic finished,
  matmul_run_ctrl_if.master bus
);
  localparam int IW = RES_WORDS > 1 ? $clog2(RES_WORDS) : 1;
  logic [2:0] state;
  logic [IW-1:0] idx;
  logic last, fire;
  assign last = idx == IW'(RES_WORDS - 1);
  assign fire = state == S_SEND && bus.res_ready;
  assign finished = fire && last;
  assign bus.rd_en = state == S_RD_REQ;
  assign bus.rd_addr = bus.rd_en ? RES_BASE + AW'(idx) : '0;
  assign bus.res_valid = state == S_SEND;
  assign bus.res_last = bus.res_valid && last;
  // rd_data is only valid in the cycle after rd_en, i.e. while in RD_WAIT
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      state <= S_IDLE;
      idx <= '0;
      bus.res_data <= {DW{1'b0}};
    end else begin
      state <= go ? S_RD_REQ
        : state == S_RD_REQ ? S_RD_WAIT
        : state == S_RD_WAIT ? S_SEND
        : fire ? (last ? S_IDLE : S_RD_REQ) : state;
      idx <= go ? '0 : fire && !last ? idx + 1'b1 : idx;
      if (state == S_RD_WAIT) bus.res_data <= bus.rd_data;
    end
endmodule

// File: rtl/matmul_run_ctrl.sv
// matmul_run_ctrl: pulses START, waits for END (with timeout), then streams the DMEM result region
// Define CYCLE_COUNT_EN to report a saturating count of WAIT_END cycles on cycle_count.
module matmul_run_ctrl import matmul_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter logic [AW-1:0] RES_BASE = AW'(RES_BASE_DEF),
  parameter int RES_WORDS = 16,
  parameter int START_LEN = 2,
  parameter int unsigned TIMEOUT = 65535
)(
  input  logic clk,
  input  logic RESET_N,
  input  logic host_go,
  output logic START,
  input  logic END,
  output logic busy,
  output logic done,
  output logic timeout,
  output logic [31:0] cycle_count,
  matmul_run_ctrl_if.master bus
);
  localparam int PW = START_LEN > 1 ? $clog2(START_LEN) : 1;
  logic [2:0] state;
  logic [PW-1:0] pcnt;
  logic idle_like, launch, rd_go, rd_fin, tout_hit;
  assign idle_like = is_idle_like(state);
  assign launch = idle_like && host_go;
  assign rd_go = state == S_WAIT_END && END;
  assign START = state == S_PULSE;
  assign busy = !idle_like;
  assign done = state == S_DONE;
  assign timeout = state == S_TOUT;
`ifdef CYCLE_COUNT_EN
  logic [31:0] cnt, cnt_nx;
  assign cnt_nx = &cnt ? cnt : cnt + 32'd1;
  assign tout_hit = TIMEOUT != 0 && cnt_nx == 32'(TIMEOUT);
  assign cycle_count = cnt;
`else
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] cnt, cnt_nx;
  assign cnt_nx = cnt + 1'b1;
  assign tout_hit = TIMEOUT != 0 && cnt_nx == TW'(TIMEOUT);
  assign cycle_count = '0;
`endif
  // S_RD_REQ here stands for the whole read phase; the reader owns the sub-states
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      state <= S_IDLE;
      pcnt <= '0;
      cnt <= '0;
    end else begin
      state <= launch ? S_PULSE
        : state == S_PULSE ? (pcnt == PW'(START_LEN - 1) ? S_WAIT_END : S_PULSE)
        : state == S_WAIT_END ? (END ? S_RD_REQ : tout_hit ? S_TOUT : S_WAIT_END)
        : state == S_RD_REQ && rd_fin ? S_DONE : state;
      pcnt <= state == S_PULSE ? pcnt + 1'b1 : '0;
      cnt <= launch ? '0 : state == S_WAIT_END ? cnt_nx : cnt;
    end
  matmul_res_reader #(.DW(DW), .AW(AW), .RES_BASE(RES_BASE), .RES_WORDS(RES_WORDS)) u_reader (
    .clk(clk),
    .RESET_N(RESET_N),
    .go(rd_go),
    .finished(rd_fin),
    .bus(bus)
  );
endmodule
